// File: rtl/hilo_muldiv_if.sv
// Execute-stage handshake between the decoder/writeback side and the HI/LO mul/div unit.
interface hilo_muldiv_if #(
   parameter int DATA_W = 32
) ();
   logic              start;
   logic [5:0]        func_code;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic              mfhi_en;
   logic              mflo_en;
   logic [DATA_W-1:0] hilo_rd_data;
   logic              busy;
   logic              stall;
   logic              done;
   logic              div_by_zero;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output start, func_code, rs_val, rt_val, mfhi_en, mflo_en,
      input  hilo_rd_data, busy, stall, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, func_code, rs_val, rt_val, mfhi_en, mflo_en,
      output hilo_rd_data, busy, stall, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle mult/multu/div/divu with architectural HI/LO: sign-magnitude front end,
// DATA_W-iteration shift-add or restoring-divide core, then sign fix-up and HI/LO write.
//
// state | meaning
// IDLE  | waiting for a mul/div func_code with start
// RUN   | one multiply/divide iteration per edge, DATA_W edges
// FIX   | sign correction, HI/LO write, done pulse follows
module hilo_muldiv_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input logic          clk,
   input logic          rst,
   hilo_muldiv_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                is_div_q;
   logic                neg_res_q;
   logic                neg_rem_q;
   logic                div_zero_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [2*DATA_W-1:0] prod_q;
   logic [DATA_W:0]     rem_q;
   logic [DATA_W-1:0]   quo_q;
   logic [DATA_W-1:0]   hi_q;
   logic [DATA_W-1:0]   lo_q;
   logic                busy_q;
   logic                done_q;
   logic                dz_pulse_q;

   logic                accept;
   logic                op_div;
   logic                sign_a;
   logic                sign_b;
   logic [DATA_W-1:0]   mag_a;
   logic [DATA_W-1:0]   mag_b;
   logic [DATA_W:0]     mul_sum;
   logic [2*DATA_W-1:0] prod_d;
   logic [DATA_W:0]     rem_sh;
   logic [DATA_W+1:0]   rem_diff;
   logic                rem_ok;
   logic [DATA_W:0]     rem_d;
   logic [DATA_W-1:0]   quo_d;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   always_comb begin
      accept = (state_q == S_IDLE) && bus.start && (bus.func_code[5:2] == 4'b0110);
      op_div = bus.func_code[1];
      // func_code[0] set means the unsigned variant
      sign_a = ~bus.func_code[0] & bus.rs_val[DATA_W-1];
      sign_b = ~bus.func_code[0] & bus.rt_val[DATA_W-1];
      mag_a  = sign_a ? -bus.rs_val : bus.rs_val;
      mag_b  = sign_b ? -bus.rt_val : bus.rt_val;

      mul_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, a_q} : '0);
      prod_d  = {mul_sum, prod_q[DATA_W-1:1]};

      // rem_diff carries one extra bit so a borrow shows up as its MSB
      rem_sh   = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
      rem_diff = {rem_q, quo_q[DATA_W-1]} - {2'b00, b_q};
      rem_ok   = ~rem_diff[DATA_W+1];
      rem_d    = rem_ok ? rem_diff[DATA_W:0] : rem_sh;
      quo_d    = {quo_q[DATA_W-2:0], rem_ok};

      prod_fix = neg_res_q ? -prod_q : prod_q;
      quo_fix  = neg_res_q ? -quo_q : quo_q;
      rem_fix  = neg_rem_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         prod_q     <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dz_pulse_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         dz_pulse_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_q    <= S_RUN;
                  busy_q     <= 1'b1;
                  cnt_q      <= '0;
                  is_div_q   <= op_div;
                  neg_res_q  <= sign_a ^ sign_b;
                  neg_rem_q  <= sign_a;
                  div_zero_q <= op_div && (bus.rt_val == '0);
                  a_q        <= mag_a;
                  b_q        <= mag_b;
                  prod_q     <= {{DATA_W{1'b0}}, mag_b};
                  rem_q      <= '0;
                  quo_q      <= mag_a;
               end
            end
            S_RUN: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (is_div_q) begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
               end else begin
                  prod_q <= prod_d;
               end
               if (cnt_q == LAST_ITER) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               // divide-by-zero: the core already leaves |A| as remainder, only LO is forced
               hi_q       <= is_div_q ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
               lo_q       <= is_div_q ? (div_zero_q ? '1 : quo_fix) : prod_fix[DATA_W-1:0];
               done_q     <= 1'b1;
               dz_pulse_q <= div_zero_q;
               busy_q     <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.div_by_zero  = dz_pulse_q;
   assign bus.hi           = hi_q;
   assign bus.lo           = lo_q;
   assign bus.stall        = (bus.mfhi_en | bus.mflo_en) & busy_q;
   assign bus.hilo_rd_data = bus.mfhi_en ? hi_q : (bus.mflo_en ? lo_q : '0);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_hilo_muldiv_unit;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hilo_muldiv_if #(.DATA_W(32)) bus ();

   hilo_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rhi, output logic [31:0] rlo, output bit rdz);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      rdz = 1'b0;
      rhi = '0;
      rlo = '0;
      if (f == F_MULT) begin
         p = sa * sb;
         rhi = p[63:32];
         rlo = p[31:0];
      end else if (f == F_MULTU) begin
         p = {32'b0, a} * {32'b0, b};
         rhi = p[63:32];
         rlo = p[31:0];
      end else if (b == 32'd0) begin
         rhi = a;
         rlo = '1;
         rdz = 1'b1;
      end else begin
         if (f == F_DIVU) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
         end
         q = sa / sb;
         r = sa % sb;
         rhi = r[31:0];
         rlo = q[31:0];
      end
   endfunction

   // Issue one op and follow it to done; optionally hold start with another op, or raise mflo mid-flight.
   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input int mflo_at);
      logic [31:0] ehi, elo;
      bit edz, seen;
      int n, busy_cnt;
      ref_op(f, a, b, ehi, elo, edz);
      @(negedge clk);
      bus.start = 1'b1; bus.func_code = f; bus.rs_val = a; bus.rt_val = b;
      @(posedge clk); #1;
      if (hold) begin
         bus.func_code = F_DIV; bus.rs_val = $urandom; bus.rt_val = $urandom;
      end else begin
         bus.start = 1'b0;
      end
      n = 0;
      seen = 1'b0;
      busy_cnt = bus.busy ? 1 : 0;
      while (n < 40 && !seen) begin
         @(posedge clk); #1;
         n++;
         if (bus.busy) busy_cnt++;
         if (bus.done) seen = 1'b1;
         if (bus.mflo_en) chk("stall", 32'(bus.stall), 32'(n < 33));
         if (mflo_at >= 0 && n == mflo_at) bus.mflo_en = 1'b1;
      end
      bus.start = 1'b0;
      chk("latency", 32'(n), 32'd33);
      chk("busy_cycles", 32'(busy_cnt), 32'd33);
      chk("hi", bus.hi, ehi);
      chk("lo", bus.lo, elo);
      chk("dz_with_done", 32'(bus.div_by_zero), 32'(edz));
      if (mflo_at >= 0) begin
         chk("mflo_rd", bus.hilo_rd_data, elo);
         bus.mflo_en = 1'b0;
      end
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("dz_one_cycle", 32'(bus.div_by_zero), 32'd0);
      last_hi = ehi;
      last_lo = elo;
   endtask

   initial begin
      logic [5:0] f;
      logic [31:0] a, b;
      bit saw_done;

      rst = 1'b1;
      bus.start = 1'b0; bus.func_code = '0; bus.rs_val = '0; bus.rt_val = '0;
      bus.mfhi_en = 1'b0; bus.mflo_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_dz", 32'(bus.div_by_zero), 32'd0);

      // non mul/div func_code with start is ignored
      @(negedge clk);
      bus.start = 1'b1; bus.func_code = 6'b100000; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("illegal_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      chk("illegal_done", 32'(bus.done), 32'd0);

      run_op(F_MULT,  32'd7,        32'hFFFFFFFD, 1'b0, -1);
      run_op(F_MULTU, 32'd7,        32'hFFFFFFFD, 1'b0, -1);
      run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1);
      run_op(F_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, -1);
      run_op(F_DIVU,  32'd100,      32'd7,        1'b0, -1);
      run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, -1);
      run_op(F_DIVU,  32'd5,        32'd0,        1'b0, -1);
      run_op(F_DIV,   32'hFFFFFFFB, 32'd0,        1'b0, -1);
      run_op(F_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, -1);
      run_op(F_MULT,  32'h12345678, 32'h9ABCDEF0, 1'b0, 5);
      run_op(F_MULT,  32'hFFFFFFF0, 32'd9,        1'b1, -1);

      @(negedge clk);
      bus.mfhi_en = 1'b1; bus.mflo_en = 1'b1;
      #1 chk("rd_hi_priority", bus.hilo_rd_data, last_hi);
      chk("idle_no_stall", 32'(bus.stall), 32'd0);
      bus.mfhi_en = 1'b0;
      #1 chk("rd_lo", bus.hilo_rd_data, last_lo);
      bus.mflo_en = 1'b0;
      #1 chk("rd_none", bus.hilo_rd_data, 32'd0);

      for (int i = 0; i < 24; i++) begin
         f = F_MULT + 6'($urandom_range(0, 3));
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
         run_op(f, a, b, 1'b0, -1);
      end

      // reset in the middle of an operation discards it and clears HI/LO
      @(negedge clk);
      bus.start = 1'b1; bus.func_code = F_MULTU; bus.rs_val = 32'd11; bus.rt_val = 32'd13;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_hi", bus.hi, 32'd0);
      chk("midrst_lo", bus.lo, 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      chk("midrst_no_late_done", 32'(saw_done), 32'd0);
      chk("midrst_hold_lo", bus.lo, 32'd0);

      run_op(F_DIVU, 32'd1000, 32'd33, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
